// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the single-clock FIFO family.
//   clog2             - constant function; returns the address width for a depth
//   FIFO_STD/FIFO_FWFT - read-mode selectors for the FWFT parameter
//   default_af_thresh  - default almost-full threshold (DEPTH-2)
//   DEFAULT_AE_THRESH  - default almost-empty threshold
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEFAULT_AE_THRESH = 2;

  // Ceiling log2. Used at elaboration time to size pointers and addresses.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int default_af_thresh(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/fifo_sync_param_dpram.sv
// dpram_1clk: single-clock dual-port RAM used as FIFO storage.
//   clk     - sole clock
//   wr_en   - write strobe; wr_data is stored at wr_addr on the rising edge
//   rd_en   - read strobe; mem[rd_addr] is registered onto rd_data
//   rd_data - registered read data, holds its value while rd_en is low
// No reset: contents and the read register power up undefined.
module dpram_1clk
  import fifo_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // The FIFO never reads and writes the same address on one edge, so
  // read-during-write behaviour does not matter here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and an optional
// first-word-fall-through read mode.
//   clk, rst_n          - clock and synchronous active-low reset
//   wr_en, wr_data      - write request and data
//   rd_en               - read request (FWFT: pop of the word on rd_data)
//   rd_data             - read data
//   empty, full         - no readable word / usedw == DEPTH
//   almost_full/_empty  - usedw >= AF_THRESH / usedw <= AE_THRESH
//   usedw               - words accepted and not yet read, 0..DEPTH
//   overflow, underflow - sticky error flags, cleared by clr_err
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  DEPTH     = 16,
  parameter int  FWFT      = FIFO_STD,
  parameter int  AF_THRESH = default_af_thresh(DEPTH),
  parameter int  AE_THRESH = DEFAULT_AE_THRESH,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      usedw,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_W    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_W    = (AW+1)'(AE_THRESH);
  localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      usedw_q, usedw_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             out_valid_q, out_valid_d;
  logic             loaded_q, loaded_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             ram_has_data;
  logic             ram_rd_en;
  logic [WIDTH-1:0] ram_rd_data;

  // Next-state logic. Accept decisions look only at registered flags so the
  // producer and consumer see a clean, edge-aligned handshake.
  always_comb begin
    wr_acc       = wr_en & ~full_q;
    rd_acc       = rd_en & ~empty_q;
    ram_has_data = (wr_ptr_q != rd_ptr_q);

    // In FWFT mode rd_ptr tracks the RAM side only: the output register is
    // refilled whenever it is empty or being popped and the RAM holds a word.
    if (IS_FWFT) begin
      ram_rd_en = ram_has_data & (~out_valid_q | rd_acc);
    end else begin
      ram_rd_en = rd_acc;
    end

    wr_ptr_d = wr_ptr_q + (wr_acc ? ONE_W : '0);
    rd_ptr_d = rd_ptr_q + (ram_rd_en ? ONE_W : '0);

    usedw_d = usedw_q;
    if (wr_acc && !rd_acc) begin
      usedw_d = usedw_q + ONE_W;
    end else if (!wr_acc && rd_acc) begin
      usedw_d = usedw_q - ONE_W;
    end

    out_valid_d = ram_rd_en | (out_valid_q & ~rd_acc);
    loaded_d    = loaded_q | ram_rd_en;

    // Standard mode uses the extra pointer bit to tell full from empty; in
    // FWFT mode the prefetched word lives outside the RAM, so the count is
    // the authority.
    if (IS_FWFT) begin
      full_d  = (usedw_d == DEPTH_W);
      empty_d = ~out_valid_d;
    end else begin
      full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_d = (wr_ptr_d == rd_ptr_d);
    end

    almost_full_d  = (usedw_d >= AF_W);
    almost_empty_d = (usedw_d <= AE_W);

    // A new error in the same cycle as clr_err must not be lost.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      usedw_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      loaded_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      usedw_q        <= usedw_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      out_valid_q    <= out_valid_d;
      loaded_q       <= loaded_d;
    end
  end

  // RAM strobes are gated with reset so requests during reset have no effect.
  dpram_1clk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc & rst_n),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en & rst_n),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset; mask it until the first word has
  // been loaded since reset so rd_data reads as zero after reset.
  assign rd_data      = loaded_q ? ram_rd_data : '0;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign usedw        = usedw_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: drives identical stimulus into a standard-mode and an
// FWFT-mode FIFO (WIDTH=8, DEPTH=16) and checks both against a queue model
// every cycle, plus directed literal expectations.
module tb_fifo_sync_param;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] wr_data;

  logic [7:0] rd_data_s, rd_data_f;
  logic       empty_s, empty_f, full_s, full_f;
  logic       af_s, af_f, ae_s, ae_f;
  logic [4:0] usedw_s, usedw_f;
  logic       ovf_s, ovf_f, unf_s, unf_f;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data_s), .empty(empty_s), .full(full_s),
    .almost_full(af_s), .almost_empty(ae_s), .usedw(usedw_s),
    .overflow(ovf_s), .underflow(unf_s), .clr_err(clr_err)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data_f), .empty(empty_f), .full(full_f),
    .almost_full(af_f), .almost_empty(ae_f), .usedw(usedw_f),
    .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 = standard mode, 1 = FWFT. Each model is a
  // circular list of stored words plus the edge number at which each word
  // was written. A word in FWFT mode becomes readable one edge after it was
  // written.
  int         m_cnt   [2];
  int         m_head  [2];
  logic [7:0] m_mem   [2][DEPTH];
  int         m_wedge [2][DEPTH];
  logic [7:0] m_rdq   [2];
  bit         m_ovf   [2];
  bit         m_unf   [2];
  int         edge_n  = 0;
  bit         started = 0;

  function automatic bit m_empty(input int m);
    if (m_cnt[m] == 0) return 1'b1;
    if (m == 1 && m_wedge[m][m_head[m]] == edge_n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge using the inputs the DUTs sample.
  always @(posedge clk) begin
    bit we, re, was_full, was_empty;
    int slot;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] = 0; m_head[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_rdq[m] = 8'h00;
      end
      started = 1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        was_full  = (m_cnt[m] == DEPTH);
        was_empty = m_empty(m);
        re = rd_en && !was_empty;
        we = wr_en && !was_full;
        if (clr_err) begin m_ovf[m] = 0; m_unf[m] = 0; end
        if (wr_en && was_full) m_ovf[m] = 1;
        if (rd_en && was_empty) m_unf[m] = 1;
        if (re) begin
          if (m == 0) m_rdq[m] = m_mem[m][m_head[m]];
          m_head[m] = (m_head[m] + 1) % DEPTH;
          m_cnt[m]--;
        end
        if (we) begin
          slot = (m_head[m] + m_cnt[m]) % DEPTH;
          m_mem[m][slot]   = wr_data;
          m_wedge[m][slot] = edge_n + 1;
          m_cnt[m]++;
        end
      end
    end
    edge_n++;
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("std.usedw", usedw_s, m_cnt[0]);
      checkOutput("std.empty", empty_s, int'(m_empty(0)));
      checkOutput("std.full", full_s, int'(m_cnt[0] == DEPTH));
      checkOutput("std.almost_full", af_s, int'(m_cnt[0] >= DEPTH - 2));
      checkOutput("std.almost_empty", ae_s, int'(m_cnt[0] <= 2));
      checkOutput("std.overflow", ovf_s, int'(m_ovf[0]));
      checkOutput("std.underflow", unf_s, int'(m_unf[0]));
      checkOutput("std.rd_data", rd_data_s, m_rdq[0]);
      checkOutput("fwft.usedw", usedw_f, m_cnt[1]);
      checkOutput("fwft.empty", empty_f, int'(m_empty(1)));
      checkOutput("fwft.full", full_f, int'(m_cnt[1] == DEPTH));
      checkOutput("fwft.almost_full", af_f, int'(m_cnt[1] >= DEPTH - 2));
      checkOutput("fwft.almost_empty", ae_f, int'(m_cnt[1] <= 2));
      checkOutput("fwft.overflow", ovf_f, int'(m_ovf[1]));
      checkOutput("fwft.underflow", unf_f, int'(m_unf[1]));
      if (!m_empty(1)) checkOutput("fwft.rd_data", rd_data_f, m_mem[1][m_head[1]]);
    end
  end

  // One clock of stimulus; returns 1 ns after the edge with outputs settled.
  task automatic applyStimulus(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("lit.reset.usedw", usedw_s, 0);
    checkOutput("lit.reset.empty", empty_s, 1);
    checkOutput("lit.reset.almost_empty", ae_s, 1);
    checkOutput("lit.reset.full", full_s, 0);
    checkOutput("lit.reset.rd_data_std", rd_data_s, 0);
    checkOutput("lit.reset.rd_data_fwft", rd_data_f, 0);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, watching the threshold flags on the way up.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 8'(i), 0);
      if (i == 1)  checkOutput("lit.fill.ae_at2", ae_s, 1);
      if (i == 2)  checkOutput("lit.fill.ae_at3", ae_s, 0);
      if (i == 12) checkOutput("lit.fill.af_at13", af_s, 0);
      if (i == 13) checkOutput("lit.fill.af_at14", af_s, 1);
    end
    checkOutput("lit.fill.full", full_s, 1);
    checkOutput("lit.fill.usedw", usedw_s, 16);
    checkOutput("lit.fill.full_fwft", full_f, 1);
    applyStimulus(1, 0, 8'hFF, 0);
    checkOutput("lit.ovf.std", ovf_s, 1);
    checkOutput("lit.ovf.fwft", ovf_f, 1);
    checkOutput("lit.ovf.usedw", usedw_s, 16);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("lit.drain.rd_data", rd_data_s, i);
    end
    checkOutput("lit.drain.empty_std", empty_s, 1);
    checkOutput("lit.drain.empty_fwft", empty_f, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("lit.clr.ovf", ovf_s, 0);

    // Streaming at usedw=5; 40 cycles carries the pointers past 2*DEPTH.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 8'h25 + 8'(i), 0);
      checkOutput("lit.stream.usedw", usedw_s, 5);
      checkOutput("lit.stream.rd_std", rd_data_s, 8'h20 + 8'(i));
      checkOutput("lit.stream.rd_fwft", rd_data_f, 8'h21 + 8'(i));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("lit.stream.tail", rd_data_s, 8'h48 + 8'(i));
    end

    // Simultaneous read and write at full, then at empty.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 8'h50 + 8'(i), 0);
    applyStimulus(1, 1, 8'h77, 0);
    checkOutput("lit.atfull.usedw", usedw_s, 15);
    checkOutput("lit.atfull.ovf", ovf_s, 1);
    checkOutput("lit.atfull.rd_std", rd_data_s, 8'h50);
    checkOutput("lit.atfull.usedw_fwft", usedw_f, 15);
    checkOutput("lit.atfull.rd_fwft", rd_data_f, 8'h51);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("lit.atfull.drain", rd_data_s, 8'h51 + 8'(i));
    end
    applyStimulus(1, 1, 8'h88, 0);
    checkOutput("lit.atempty.usedw", usedw_s, 1);
    checkOutput("lit.atempty.unf", unf_s, 1);
    checkOutput("lit.atempty.hold", rd_data_s, 8'h5F);
    checkOutput("lit.atempty.fwft_empty", empty_f, 1);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("lit.atempty.fwft_show", rd_data_f, 8'h88);
    checkOutput("lit.atempty.fwft_valid", empty_f, 0);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("lit.atempty.rd_std", rd_data_s, 8'h88);

    // FWFT fall-through timing.
    applyStimulus(1, 0, 8'hA5, 0);
    checkOutput("lit.fwft.k_empty", empty_f, 1);
    applyStimulus(1, 0, 8'hB6, 0);
    checkOutput("lit.fwft.k1_empty", empty_f, 0);
    checkOutput("lit.fwft.k1_data", rd_data_f, 8'hA5);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("lit.fwft.pop_next", rd_data_f, 8'hB6);
    checkOutput("lit.fwft.std_rd", rd_data_s, 8'hA5);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("lit.fwft.std_rd2", rd_data_s, 8'hB6);

    // Error-flag clear priority.
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("lit.err.cleared", unf_s, 0);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("lit.err.set_wins", unf_s, 1);
    checkOutput("lit.err.set_wins_fwft", unf_f, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("lit.err.clr_alone", unf_s, 0);

    // Reset with data in flight.
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 8'hC0 + 8'(i), 0);
    checkOutput("lit.rst.usedw_before", usedw_s, 9);
    rst_n = 1'b0;
    applyStimulus(1, 1, 8'hEE, 0);
    checkOutput("lit.rst.usedw", usedw_s, 0);
    checkOutput("lit.rst.empty", empty_s, 1);
    checkOutput("lit.rst.rd_std", rd_data_s, 0);
    checkOutput("lit.rst.usedw_fwft", usedw_f, 0);
    checkOutput("lit.rst.rd_fwft", rd_data_f, 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 8'h5A, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("lit.rst.fwft_new", rd_data_f, 8'h5A);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("lit.rst.std_new", rd_data_s, 8'h5A);
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
